fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined processor. Holds the PC, reads the instruction memory, and registers the fetched word. It feeds `opcode`/`funct` straight into the main control decoder and the register fields into the register file. It applies hazard stalls, branch/jump redirects with flush, and stops fetching when a Halt (opcode 1111) is fetched.

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined
// processor. Holds the program counter, addresses the instruction memory
// (combinational read), and registers the fetched word together with its
// return address (pc + 2). The register fields are fanned out directly to the
// control decoder and register file.
//
// Control:
//   - stall from the hazard unit freezes pc, IF/ID and the fetch state.
//   - branch_taken (resolved in EX, older than IF/ID) redirects and flushes,
//     overriding everything except reset.
//   - jump (decoded from the IF/ID instruction) redirects and flushes unless
//     the jump itself is being held by a stall.
//   - Fetching a Halt (opcode 4'b1111) parks the pc on the Halt and enters
//     HALTED, where only bubbles are issued until reset or a redirect.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   hold pc and IF/ID
//   jump           in   jump redirect for the IF/ID instruction
//   jump_target    in   [15:0] jump destination
//   branch_taken   in   taken-branch redirect from EX
//   branch_target  in   [15:0] branch destination
//   imem_addr      out  [15:0] instruction memory address (= pc)
//   imem_rdata     in   [15:0] instruction word at imem_addr, same cycle
//   opcode         out  [3:0] ifid_instr[15:12]
//   op1            out  [3:0] ifid_instr[11:8]
//   op2            out  [3:0] ifid_instr[7:4]
//   funct          out  [3:0] ifid_instr[3:0]
//   ifid_pc        out  [15:0] address of IF/ID instruction plus 2
//   ifid_valid     out  IF/ID holds a real instruction
//   halted         out  fetch stopped after a Halt
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [3:0]  opcode,
  output logic [3:0]  op1,
  output logic [3:0]  op2,
  output logic [3:0]  funct,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
);

  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ifid_instr;

  // Sequential pc + 2; the 16-bit result wraps 16'hFFFE -> 16'h0000.
  logic [15:0] pc_next_seq;
  logic        fetched_halt;

  assign pc_next_seq  = pc + 16'd2;
  assign fetched_halt = (imem_rdata[15:12] == HALT_OPCODE);

  // Fetch FSM, pc and IF/ID register. The if/else chain encodes the redirect
  // priority: reset, branch, stall, jump, then normal fetch / halted drain.
  // NOTE: every state element here is assigned with <= so all of them update
  // from the same pre-edge values; blocking assignments would let later
  // statements see half-updated state and the simulation would diverge from
  // the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      // The branch is older than anything in IF or IF/ID, so both are wrong
      // path; this also cancels a Halt fetched on that path.
      state      <= RUN;
      pc         <= branch_target;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      // Hold everything. A pending jump is not lost: the jump instruction
      // itself stays in IF/ID and is re-presented once the stall drops.
      state      <= state;
      pc         <= pc;
      ifid_instr <= ifid_instr;
      ifid_pc    <= ifid_pc;
      ifid_valid <= ifid_valid;
    end else if (jump) begin
      // The word fetched this cycle sits behind the jump: replace it with
      // a single bubble. A Halt fetched behind the jump was wrong path too.
      state      <= RUN;
      pc         <= jump_target;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          ifid_instr <= imem_rdata;
          ifid_pc    <= pc_next_seq;
          ifid_valid <= 1'b1;
          if (fetched_halt) begin
            // Park on the Halt; it drains downstream exactly once.
            state <= HALTED;
            pc    <= pc;
          end else begin
            state <= RUN;
            pc    <= pc_next_seq;
          end
        end
        HALTED: begin
          state      <= HALTED;
          pc         <= pc;
          ifid_instr <= NOP_INSTR;
          ifid_pc    <= 16'h0000;
          ifid_valid <= 1'b0;
        end
        default: begin
          state      <= RUN;
          pc         <= pc;
          ifid_instr <= NOP_INSTR;
          ifid_pc    <= 16'h0000;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: straight wires off the registers, so every output is a flop.
  assign imem_addr = pc;
  assign opcode    = ifid_instr[15:12];
  assign op1       = ifid_instr[11:8];
  assign op2       = ifid_instr[7:4];
  assign funct     = ifid_instr[3:0];
  assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A bench-owned instruction memory
// answers imem_addr combinationally. A behavioural model (program counter,
// IF/ID word and halted flag as plain variables) is advanced after every
// rising edge from the same inputs and its own memory lookup; after every
// edge the DUT outputs are compared with it on the falling edge. Directed
// scenarios add hand-computed literal expectations, then a randomized phase
// exercises arbitrary mixes of reset, stall, jump, branch and Halt words.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode;
  logic [3:0]  op1;
  logic [3:0]  op2;
  logic [3:0]  funct;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;

  // Word-addressed backing store for byte addresses (addr >> 1).
  logic [15:0] mem [0:32767];

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [15:0] m_pc      = 16'h0000;
  logic [15:0] m_instr   = NOP;
  logic [15:0] m_ifid_pc = 16'h0000;
  logic        m_valid   = 1'b0;
  logic        m_halted  = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .opcode        (opcode),
    .op1           (op1),
    .op2           (op2),
    .funct         (funct),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_instr   = NOP;
    m_valid   = 1'b0;
    m_ifid_pc = 16'h0000;
  endtask

  // One clock edge of the reference behaviour, written as the rule list.
  task automatic model_edge();
    logic [15:0] w;
    if (rst) begin
      m_pc = 16'h0000; model_bubble(); m_halted = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target; model_bubble(); m_halted = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (jump) begin
      m_pc = jump_target; model_bubble(); m_halted = 1'b0;
    end else if (m_halted) begin
      model_bubble();
    end else begin
      w         = mem[m_pc >> 1];
      m_instr   = w;
      m_valid   = 1'b1;
      m_ifid_pc = m_pc + 16'd2;
      if (w[15:12] == 4'hF) m_halted = 1'b1;
      else                  m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic compare_model();
    check("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
    check("opcode", {28'h0, opcode}, {28'h0, m_instr[15:12]});
    check("op1", {28'h0, op1}, {28'h0, m_instr[11:8]});
    check("op2", {28'h0, op2}, {28'h0, m_instr[7:4]});
    check("funct", {28'h0, funct}, {28'h0, m_instr[3:0]});
    check("ifid_pc", {16'h0, ifid_pc}, {16'h0, m_ifid_pc});
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    check("halted", {31'h0, halted}, {31'h0, m_halted});
  endtask

  // Advance one cycle: edge, model update, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 16'h0000; branch_target = 16'h0000;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    // Random background program without Halts, then the directed words.
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (r[15:12] == 4'hF) r[15:12] = 4'h7;
      mem[i] = r;
    end
    mem[16'h0000 >> 1] = 16'h0123;
    mem[16'h0002 >> 1] = 16'h8456;
    mem[16'h0004 >> 1] = 16'hB789;
    mem[16'h0006 >> 1] = 16'hC000;
    mem[16'h0008 >> 1] = 16'hF000;
    mem[16'h0020 >> 1] = 16'h4567;
    mem[16'h0040 >> 1] = 16'h2345;
    mem[16'h0100 >> 1] = 16'h3111;
    mem[16'hFFFE >> 1] = 16'h5AAA;

    idle();
    rst = 1'b1;

    // ---- Reset ----
    tick(); tick();
    lit("rst_addr", {16'h0, imem_addr}, 32'h0);
    lit("rst_opcode", {28'h0, opcode}, 32'h1);
    lit("rst_valid", {31'h0, ifid_valid}, 32'h0);
    lit("rst_halted", {31'h0, halted}, 32'h0);
    lit("rst_ifid_pc", {16'h0, ifid_pc}, 32'h0);

    // ---- Sequential fetch ----
    rst = 1'b0;
    tick();
    lit("seq0_opcode", {28'h0, opcode}, 32'h0);
    lit("seq0_ifid_pc", {16'h0, ifid_pc}, 32'h2);
    lit("seq0_valid", {31'h0, ifid_valid}, 32'h1);
    tick();
    lit("seq1_opcode", {28'h0, opcode}, 32'h8);
    lit("seq1_ifid_pc", {16'h0, ifid_pc}, 32'h4);

    // ---- Stall 3 cycles with 0x8456 in IF/ID ----
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("stall_opcode", {28'h0, opcode}, 32'h8);
      lit("stall_funct", {28'h0, funct}, 32'h6);
      lit("stall_pc", {16'h0, imem_addr}, 32'h4);
    end
    stall = 1'b0;
    tick();
    lit("post_stall_opcode", {28'h0, opcode}, 32'hB);
    lit("post_stall_ifid_pc", {16'h0, ifid_pc}, 32'h6);

    // ---- Jump with IF/ID = 0xC000 ----
    tick();
    lit("jmp_src_opcode", {28'h0, opcode}, 32'hC);
    jump = 1'b1; jump_target = 16'h0040;
    tick();
    lit("jmp_bubble_opcode", {28'h0, opcode}, 32'h1);
    lit("jmp_bubble_valid", {31'h0, ifid_valid}, 32'h0);
    lit("jmp_addr", {16'h0, imem_addr}, 32'h40);
    idle();
    tick();
    lit("jmp_tgt_opcode", {28'h0, opcode}, 32'h2);
    lit("jmp_tgt_funct", {28'h0, funct}, 32'h5);
    lit("jmp_tgt_ifid_pc", {16'h0, ifid_pc}, 32'h42);

    // ---- stall + jump + branch: branch wins ----
    stall = 1'b1; jump = 1'b1; jump_target = 16'h0200;
    branch_taken = 1'b1; branch_target = 16'h0100;
    tick();
    lit("prio_addr", {16'h0, imem_addr}, 32'h100);
    lit("prio_valid", {31'h0, ifid_valid}, 32'h0);
    idle();
    tick();
    lit("br_tgt_opcode", {28'h0, opcode}, 32'h3);
    // stall + jump only: all holds
    stall = 1'b1; jump = 1'b1; jump_target = 16'h0300;
    tick();
    lit("sj_addr", {16'h0, imem_addr}, 32'h102);
    lit("sj_opcode", {28'h0, opcode}, 32'h3);
    lit("sj_valid", {31'h0, ifid_valid}, 32'h1);
    idle();

    // ---- Halt at 0x0008 ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();   // fetch 0,2,4,6,8
    lit("halt_opcode", {28'h0, opcode}, 32'hF);
    lit("halt_flag", {31'h0, halted}, 32'h1);
    lit("halt_addr", {16'h0, imem_addr}, 32'h8);
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("halted_valid", {31'h0, ifid_valid}, 32'h0);
      lit("halted_flag", {31'h0, halted}, 32'h1);
      lit("halted_addr", {16'h0, imem_addr}, 32'h8);
    end
    branch_taken = 1'b1; branch_target = 16'h0020;
    tick();
    lit("resume_halted", {31'h0, halted}, 32'h0);
    lit("resume_addr", {16'h0, imem_addr}, 32'h20);
    idle();
    tick();
    lit("resume_opcode", {28'h0, opcode}, 32'h4);
    lit("resume_ifid_pc", {16'h0, ifid_pc}, 32'h22);

    // ---- Reset while halted ----
    jump = 1'b1; jump_target = 16'h0008;
    tick();
    idle();
    tick();
    lit("rehalt_flag", {31'h0, halted}, 32'h1);
    rst = 1'b1;
    tick();
    lit("rst_halt_flag", {31'h0, halted}, 32'h0);
    lit("rst_halt_addr", {16'h0, imem_addr}, 32'h0);
    rst = 1'b0;

    // ---- PC wrap at 0xFFFE ----
    jump = 1'b1; jump_target = 16'hFFFE;
    tick();
    idle();
    tick();
    lit("wrap_opcode", {28'h0, opcode}, 32'h5);
    lit("wrap_ifid_pc", {16'h0, ifid_pc}, 32'h0);
    lit("wrap_addr", {16'h0, imem_addr}, 32'h0);

    // ---- Randomized phase, Halt words now included ----
    for (int i = 0; i < 512; i++) mem[$urandom_range(32767, 0)][15:12] = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99, 0) < 1);
      branch_taken  = ($urandom_range(99, 0) < 5);
      stall         = ($urandom_range(99, 0) < 20);
      jump          = ($urandom_range(99, 0) < 8);
      jump_target   = {15'($urandom), 1'b0};
      branch_target = {15'($urandom), 1'b0};
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
